// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: 1280x720p60 constants, frame-size helpers,
// the pipeline payload type and the RGB565 -> RGB888 expansion used by both
// the capture path and the HDMI output path.
package video_timing_pkg;

  // 1280x720p60 horizontal timing, in pixel clocks
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;

  // 1280x720p60 vertical timing, in lines
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // Both raster counters are 12 bits wide, enough for 1650 x 750
  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  // Everything that has to travel alongside the read-buffer latency
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    cnt_t x;
    cnt_t y;
  } sync_bus_t;

  localparam int SYNC_BUS_W = $bits(sync_bus_t);

  // Clocks per line
  function automatic int h_total(input int sync_w, input int bp, input int active, input int fp);
    return sync_w + bp + active + fp;
  endfunction

  // Lines per frame
  function automatic int v_total(input int sync_w, input int bp, input int active, input int fp);
    return sync_w + bp + active + fp;
  endfunction

  // Expand RGB565 to RGB888 by replicating the top bits of each channel into
  // the new low bits, so full-scale stays full-scale and zero stays zero
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] pix);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = pix[15:11];
    g6 = pix[10:5];
    b5 = pix[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised shift register with asynchronous active-low reset. Used to
// carry sync/enable/coordinate information across the read-buffer latency.
module sync_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             rd_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the input
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers, cleared by reset
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/hdmi_timing_gen.sv
// HDMI video timing source and output formatter. Produces the vsync/href
// request pair for the DDR read buffer, re-aligns sync with the pixel data
// that comes back PIPE_DLY clocks later, expands RGB565 to RGB888 and paints
// the splice-boundary grid on top.
module hdmi_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          H_ACTIVE   = H_ACTIVE_720P,
  parameter int          H_FP       = H_FP_720P,
  parameter int          H_SYNC     = H_SYNC_720P,
  parameter int          H_BP       = H_BP_720P,
  parameter int          V_ACTIVE   = V_ACTIVE_720P,
  parameter int          V_FP       = V_FP_720P,
  parameter int          V_SYNC     = V_SYNC_720P,
  parameter int          V_BP       = V_BP_720P,
  parameter int          PIPE_DLY   = 2,
  parameter bit          GRID_EN    = 1'b1,
  parameter logic [23:0] GRID_COLOR = 24'hFFFFFF
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic        timing_en,
  output logic        hdmi_vsync,
  output logic        hdmi_href,
  input  logic        de_i,
  input  logic [15:0] rgb565_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] rgb_o,
  output logic        align_err
);

  // Region boundaries; each axis runs sync -> back porch -> active -> front porch
  localparam cnt_t H_LAST      = cnt_t'(h_total(H_SYNC, H_BP, H_ACTIVE, H_FP) - 1);
  localparam cnt_t V_LAST      = cnt_t'(v_total(V_SYNC, V_BP, V_ACTIVE, V_FP) - 1);
  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC);
  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_BEG   = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE);
  localparam cnt_t V_ACT_BEG   = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  // Splice boundaries in active coordinates: a full-width horizontal line at
  // a quarter of the height, and a vertical line at three quarters of the
  // width that only runs below the horizontal one
  localparam cnt_t GRID_Y      = cnt_t'(V_ACTIVE / 4);
  localparam cnt_t GRID_X      = cnt_t'((3 * H_ACTIVE) / 4);

  // Raster counters
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // First registered stage: the request pair and internal timing
  logic hdmi_vsync_q, hdmi_vsync_d;
  logic hdmi_href_q,  hdmi_href_d;
  logic hs_q,         hs_d;
  cnt_t x_q,          x_d;
  cnt_t y_q,          y_d;

  logic h_active;
  logic v_active;

  // Delay-line payload
  sync_bus_t dly_in;
  sync_bus_t dly_out;

  // Output stage
  logic        hs_o_q,      hs_o_d;
  logic        vs_o_q,      vs_o_d;
  logic        de_o_q,      de_o_d;
  logic [23:0] rgb_o_q,     rgb_o_d;
  logic        align_err_q, align_err_d;

  logic        on_grid;
  logic [23:0] pix_888;

  // Raster counter advance; a disabled generator parks at the frame origin
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!timing_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + cnt_t'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + cnt_t'(1);
    end
  end

  // Raster counter registers
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode the current raster position into sync, request and active coordinates
  always_comb begin
    h_active     = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    v_active     = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    hdmi_href_d  = timing_en && h_active && v_active;
    hdmi_vsync_d = timing_en && (v_cnt_q < V_SYNC_END);
    hs_d         = timing_en && (h_cnt_q < H_SYNC_END);
    x_d          = h_cnt_q - H_ACT_BEG;
    y_d          = v_cnt_q - V_ACT_BEG;
  end

  // Register the decoded timing; hdmi_href/hdmi_vsync leave the block from here
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      hdmi_href_q  <= 1'b0;
      hdmi_vsync_q <= 1'b0;
      hs_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
    end else begin
      hdmi_href_q  <= hdmi_href_d;
      hdmi_vsync_q <= hdmi_vsync_d;
      hs_q         <= hs_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  assign hdmi_href  = hdmi_href_q;
  assign hdmi_vsync = hdmi_vsync_q;

  // Pack the timing that must wait for the read buffer to answer
  always_comb begin
    dly_in    = '0;
    dly_in.hs = hs_q;
    dly_in.vs = hdmi_vsync_q;
    dly_in.de = hdmi_href_q;
    dly_in.x  = x_q;
    dly_in.y  = y_q;
  end

  // Matching the read-buffer depth puts dly_out on the same cycle as de_i/rgb565_i
  sync_delay_line #(
    .WIDTH (SYNC_BUS_W),
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .rd_clk (rd_clk),
    .rst    (rst),
    .din    (dly_in),
    .dout   (dly_out)
  );

  // Format the returned pixel: expand, overlay the grid, blank outside de,
  // and flag any cycle where the buffer's de disagrees with ours
  always_comb begin
    pix_888     = rgb565_to_rgb888(rgb565_i);
    on_grid     = GRID_EN &&
                  ((dly_out.y == GRID_Y) || ((dly_out.y > GRID_Y) && (dly_out.x == GRID_X)));
    hs_o_d      = dly_out.hs;
    vs_o_d      = dly_out.vs;
    de_o_d      = dly_out.de;
    rgb_o_d     = '0;
    if (dly_out.de) begin
      rgb_o_d = on_grid ? GRID_COLOR : pix_888;
    end
    align_err_d = align_err_q || (de_i != dly_out.de);
  end

  // Output registers toward the HDMI transmitter; align_err is sticky until reset
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      hs_o_q      <= 1'b0;
      vs_o_q      <= 1'b0;
      de_o_q      <= 1'b0;
      rgb_o_q     <= '0;
      align_err_q <= 1'b0;
    end else begin
      hs_o_q      <= hs_o_d;
      vs_o_q      <= vs_o_d;
      de_o_q      <= de_o_d;
      rgb_o_q     <= rgb_o_d;
      align_err_q <= align_err_d;
    end
  end

  assign hs_o      = hs_o_q;
  assign vs_o      = vs_o_q;
  assign de_o      = de_o_q;
  assign rgb_o     = rgb_o_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen using a shrunken raster (23 x 13 clocks) so whole
// frames stay short. A loopback model stands in for the DDR read buffer.
module tb_hdmi_timing_gen;

  // Small raster: H 2+3+16+2 = 23, V 2+2+8+1 = 13, frame = 299 clocks
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 3;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int FRAME    = 299;
  localparam int PIX_PER_FRAME = 128;
  localparam int VS_CLKS  = 46;
  localparam int FIRST_HREF = 98;
  localparam int HQ       = 2;
  localparam int WT       = 12;
  localparam logic [23:0] GRID_COLOR = 24'hFFFFFF;

  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        timing_en = 1'b0;
  logic        hdmi_vsync;
  logic        hdmi_href;
  logic        de_i;
  logic [15:0] rgb565_i;
  logic        hs_o;
  logic        vs_o;
  logic        de_o;
  logic [23:0] rgb_o;
  logic        align_err;

  typedef struct {
    logic [15:0] color;
    logic [23:0] exp_off;
  } vec_t;

  typedef struct {
    logic [23:0] exp;
    logic        grid;
  } sb_t;

  vec_t vecs [6];
  sb_t  sb_q [$];

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          de_total = 0;
  logic [23:0] last_off_rgb = '0;
  int          cur_idx = 0;
  bit          sb_en = 1'b0;
  int          lat = 2;

  // Read-buffer loopback state
  logic        lb_de [3];
  logic [15:0] lb_pix [3];
  logic        href_p = 1'b0;
  logic        vs_p = 1'b0;
  int          bx = 0;
  int          by = 0;

  hdmi_timing_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .H_FP       (H_FP),
    .H_SYNC     (H_SYNC),
    .H_BP       (H_BP),
    .V_ACTIVE   (V_ACTIVE),
    .V_FP       (V_FP),
    .V_SYNC     (V_SYNC),
    .V_BP       (V_BP),
    .PIPE_DLY   (2),
    .GRID_EN    (1'b1),
    .GRID_COLOR (GRID_COLOR)
  ) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .timing_en  (timing_en),
    .hdmi_vsync (hdmi_vsync),
    .hdmi_href  (hdmi_href),
    .de_i       (de_i),
    .rgb565_i   (rgb565_i),
    .hs_o       (hs_o),
    .vs_o       (vs_o),
    .de_o       (de_o),
    .rgb_o      (rgb_o),
    .align_err  (align_err)
  );

  always #5 rd_clk = ~rd_clk;

  assign de_i     = (lat == 3) ? lb_de[2]  : lb_de[1];
  assign rgb565_i = (lat == 3) ? lb_pix[2] : lb_pix[1];

  // Read buffer stand-in: answers each href with the current colour after
  // lat clocks, and records what the formatter should emit for that pixel
  always @(posedge rd_clk) begin
    lb_de[0]  <= hdmi_href;
    lb_de[1]  <= lb_de[0];
    lb_de[2]  <= lb_de[1];
    lb_pix[0] <= hdmi_href ? vecs[cur_idx].color : 16'h0000;
    lb_pix[1] <= lb_pix[0];
    lb_pix[2] <= lb_pix[1];
    href_p    <= hdmi_href;
    vs_p      <= hdmi_vsync;
    if (!rst) begin
      bx <= 0;
      by <= 0;
    end else begin
      if (hdmi_vsync && !vs_p) begin
        by <= 0;
      end else if (!hdmi_href && href_p) begin
        by <= by + 1;
      end
      if (hdmi_href) begin
        bx <= bx + 1;
        if (sb_en) begin
          sb_t e;
          e.grid = (by == HQ) || ((by > HQ) && (bx == WT));
          e.exp  = e.grid ? GRID_COLOR : vecs[cur_idx].exp_off;
          sb_q.push_back(e);
        end
      end else begin
        bx <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic en_v);
    rst       = rst_v;
    timing_en = en_v;
  endtask

  // Pixel stream checker, sampled on the falling edge
  always @(negedge rd_clk) begin
    if (sb_en && rst) begin
      if (de_o) begin
        checkOutput("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          sb_t e;
          e = sb_q.pop_front();
          if (e.grid) begin
            checkOutput("grid_pixel", 32'(rgb_o), 32'(e.exp));
          end else begin
            checkOutput("pixel", 32'(rgb_o), 32'(e.exp));
            last_off_rgb = rgb_o;
          end
          de_total++;
        end
      end else begin
        checkOutput("rgb_blank", 32'(rgb_o), 32'd0);
      end
      checkOutput("align_err_low", 32'(align_err), 32'd0);
    end
  end

  initial begin
    int href_n;
    int vs_n;
    int first_href;
    int d0;
    bit found;

    vecs[0] = '{16'hF800, 24'hFF0000};
    vecs[1] = '{16'h001F, 24'h0000FF};
    vecs[2] = '{16'h07E0, 24'h00FF00};
    vecs[3] = '{16'h0000, 24'h000000};
    vecs[4] = '{16'h8410, 24'h848284};
    vecs[5] = '{16'h5AEB, 24'h5A5D5A};

    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge rd_clk);
    checkOutput("rst_vsync", 32'(hdmi_vsync), 32'd0);
    checkOutput("rst_href", 32'(hdmi_href), 32'd0);
    checkOutput("rst_hs_o", 32'(hs_o), 32'd0);
    checkOutput("rst_vs_o", 32'(vs_o), 32'd0);
    checkOutput("rst_de_o", 32'(de_o), 32'd0);
    checkOutput("rst_rgb_o", 32'(rgb_o), 32'd0);
    checkOutput("rst_align_err", 32'(align_err), 32'd0);

    // First full frame from the origin
    sb_en = 1'b1;
    applyStimulus(1'b1, 1'b1);
    href_n = 0;
    vs_n = 0;
    first_href = 0;
    d0 = de_total;
    for (int n = 1; n <= FRAME; n++) begin
      @(negedge rd_clk);
      if (n == 1) checkOutput("vsync_first_edge", 32'(hdmi_vsync), 32'd1);
      if (n == FRAME) checkOutput("vsync_last_line", 32'(hdmi_vsync), 32'd0);
      if (hdmi_href) begin
        href_n++;
        if (first_href == 0) first_href = n;
      end
      if (hdmi_vsync) vs_n++;
    end
    checkOutput("href_per_frame", 32'(href_n), 32'(PIX_PER_FRAME));
    checkOutput("vsync_clks", 32'(vs_n), 32'(VS_CLKS));
    checkOutput("first_href", 32'(first_href), 32'(FIRST_HREF));
    checkOutput("de_o_per_frame", 32'(de_total - d0), 32'(PIX_PER_FRAME));
    checkOutput("rgb_red", 32'(last_off_rgb), 32'(vecs[0].exp_off));
    @(negedge rd_clk);
    checkOutput("vsync_wrap", 32'(hdmi_vsync), 32'd1);
    checkOutput("href_wrap", 32'(hdmi_href), 32'd0);

    // One frame per colour in the table
    for (int i = 0; i < 6; i++) begin
      cur_idx = i;
      d0 = de_total;
      repeat (FRAME) @(negedge rd_clk);
      checkOutput($sformatf("de_per_frame[%0d]", i), 32'(de_total - d0), 32'(PIX_PER_FRAME));
      checkOutput($sformatf("rgb_off_grid[%0d]", i), 32'(last_off_rgb), 32'(vecs[i].exp_off));
    end
    cur_idx = 0;

    // Reset in the middle of an active line
    found = 1'b0;
    for (int n = 0; n < 2 * FRAME && !found; n++) begin
      @(negedge rd_clk);
      if (de_o && hdmi_href) found = 1'b1;
    end
    checkOutput("wait_active_line", 32'(found), 32'd1);
    #2;
    sb_en = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midrst_href", 32'(hdmi_href), 32'd0);
    checkOutput("midrst_de_o", 32'(de_o), 32'd0);
    checkOutput("midrst_rgb_o", 32'(rgb_o), 32'd0);
    sb_q.delete();

    // Read buffer one clock slower than expected
    lat = 3;
    repeat (3) @(negedge rd_clk);
    applyStimulus(1'b1, 1'b1);
    for (int n = 1; n <= 101; n++) begin
      @(negedge rd_clk);
      if (n == 100) checkOutput("align_err_before", 32'(align_err), 32'd0);
      if (n == 101) checkOutput("align_err_rise", 32'(align_err), 32'd1);
    end
    repeat (FRAME) @(negedge rd_clk);
    checkOutput("align_err_sticky", 32'(align_err), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("align_err_cleared", 32'(align_err), 32'd0);
    lat = 2;
    repeat (3) @(negedge rd_clk);
    sb_en = 1'b1;
    applyStimulus(1'b1, 1'b1);

    // Drop timing_en partway through active line 6
    for (int n = 1; n <= 148; n++) begin
      @(negedge rd_clk);
      if (n == 1) checkOutput("restart_vsync", 32'(hdmi_vsync), 32'd1);
      if (n == 148) checkOutput("href_before_drop", 32'(hdmi_href), 32'd1);
    end
    applyStimulus(1'b1, 1'b0);
    @(negedge rd_clk);
    checkOutput("href_after_drop", 32'(hdmi_href), 32'd0);
    @(negedge rd_clk);
    @(negedge rd_clk);
    checkOutput("drain_last_pixel", 32'(de_o), 32'd1);
    @(negedge rd_clk);
    checkOutput("drain_done", 32'(de_o), 32'd0);
    repeat (5) @(negedge rd_clk);
    checkOutput("disabled_vsync", 32'(hdmi_vsync), 32'd0);
    checkOutput("disabled_hs_o", 32'(hs_o), 32'd0);

    // Re-enable: the frame restarts at the origin
    applyStimulus(1'b1, 1'b1);
    first_href = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge rd_clk);
      if (n == 1) checkOutput("reenable_vsync", 32'(hdmi_vsync), 32'd1);
      if (n == 3) checkOutput("hs_o_before", 32'(hs_o), 32'd0);
      if (n == 4) begin
        checkOutput("hs_o_aligned", 32'(hs_o), 32'd1);
        checkOutput("vs_o_aligned", 32'(vs_o), 32'd1);
      end
      if (hdmi_href && first_href == 0) first_href = n;
    end
    checkOutput("reenable_first_href", 32'(first_href), 32'(FIRST_HREF));

    applyStimulus(1'b1, 1'b0);
    repeat (6) @(negedge rd_clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
